scope_controls_multi: RTL and testbench

- Parametrised front-panel controller for the DE1-SoC scope.
- Turns the 10 slide switches and 4 active-low KEY buttons into registered cursor, per-channel wave and timebase settings for the display/sampling path.
- Supports N_CH wave channels, with:
  - debounced, single-event button handling;
  - saturating (non-wrapping) adjustment;
  - optional auto-repeat on held buttons.

---
 rtl/scope_ctrl_pkg.sv | 17 +
 rtl/button_conditioner.sv | 63 ++++++
 rtl/scope_controls_multi.sv | 153 +++++++++++++++
 tb/tb_scope_controls_multi.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/scope_ctrl_pkg.sv
// scope_ctrl_pkg: shared mode encodings, reset defaults and saturation limits for scope_controls_multi.
package scope_ctrl_pkg;
    typedef enum logic [1:0] {
        MODE_CURSOR = 2'b00,
        MODE_WAVE   = 2'b01,
        MODE_RSVD   = 2'b10,
        MODE_LOCK   = 2'b11
    } mode_e;
    localparam int CUR_X1_RST  = 32;
    localparam int CUR_X2_RST  = 90;
    localparam int CUR_Y1_RST  = 25;
    localparam int CUR_Y2_RST  = 100;
    localparam int OFFSET_BASE = 30;
    localparam int OFFSET_STEP = 170;
    localparam int SHIFT_MAX   = 15;
    localparam int SA_MAX      = 63;
endpackage

// File: rtl/button_conditioner.sv
// button_conditioner: 2-flop sync, debounce, single press pulse and optional auto-repeat for one active-low KEY.
// Auto-repeat timer exists only when SCOPE_CTRL_AUTOREPEAT_EN is defined.
module button_conditioner #(
    parameter int DEB_CYCLES = 50000,
    parameter int RPT_DELAY  = 25000000,
    parameter int RPT_RATE   = 2500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_butt_n,
    output logic o_evt,
    output logic o_rpt
);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    if (DEB_CYCLES < 1 || RPT_RATE < 1 || RPT_RATE > RPT_DELAY) begin : g_bad_param
        $error("button_conditioner: need DEB_CYCLES >= 1 and 1 <= RPT_RATE <= RPT_DELAY");
    end
    logic          r_s1, r_s2, r_deb, r_deb_d, r_armed, r_evt;
    logic [DW-1:0] r_cnt;
    logic          w_diff, w_done;
    assign w_diff = r_s2 != r_deb;
    assign w_done = r_cnt == DW'(DEB_CYCLES - 1);
    assign o_evt  = r_evt;
    // Levels are stored as "pressed" = 1; reset assumes pressed so a held key needs a release first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1    <= 1'b1;
            r_s2    <= 1'b1;
            r_deb   <= 1'b1;
            r_deb_d <= 1'b1;
            r_armed <= 1'b0;
            r_evt   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_s1    <= ~i_butt_n;
            r_s2    <= r_s1;
            r_cnt   <= (w_diff && !w_done) ? r_cnt + 1'b1 : '0;
            r_deb   <= (w_diff && w_done) ? r_s2 : r_deb;
            r_deb_d <= r_deb;
            r_armed <= r_armed | ~r_deb;
            r_evt   <= r_deb & ~r_deb_d & r_armed;
        end
    end
`ifdef SCOPE_CTRL_AUTOREPEAT_EN
    localparam int RW = $clog2(RPT_DELAY + 1);
    logic [RW-1:0] r_rcnt;
    logic          r_rpt, w_held, w_fire;
    assign w_held = r_deb & r_deb_d;
    assign w_fire = w_held && r_rcnt == RW'(RPT_DELAY - 1);
    assign o_rpt  = r_rpt;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rcnt <= '0;
            r_rpt  <= 1'b0;
        end else begin
            r_rcnt <= !w_held ? '0 : w_fire ? RW'(RPT_DELAY - RPT_RATE) : r_rcnt + 1'b1;
            r_rpt  <= w_fire;
        end
    end
`else
    assign o_rpt = 1'b0;
`endif
endmodule

// File: rtl/scope_controls_multi.sv
// scope_controls_multi: front-panel controller turning switches and KEYs into cursor, wave and timebase settings.
// Define SCOPE_CTRL_AUTOREPEAT_EN to enable auto-repeat of cursor moves and offset steps on held KEYs.
module scope_controls_multi
    import scope_ctrl_pkg::*;
#(
    parameter int N_CH       = 2,
    parameter int CW         = 11,
    parameter int X_MAX      = 639,
    parameter int Y_MAX      = 479,
    parameter int DEB_CYCLES = 50000,
    parameter int RPT_DELAY  = 25000000,
    parameter int RPT_RATE   = 2500000
) (
    input  logic                buttonClock,
    input  logic                resetN,
    input  logic [9:0]          switch,
    input  logic [3:0]          butt,
    output logic [CW-1:0]       cursorX1Out,
    output logic [CW-1:0]       cursorX2Out,
    output logic [CW-1:0]       cursorY1Out,
    output logic [CW-1:0]       cursorY2Out,
    output logic                cursorX_ENOut,
    output logic                cursorY_ENOut,
    output logic [N_CH-1:0]     waveENOut,
    output logic [N_CH-1:0]     holdOut,
    output logic [N_CH*CW-1:0]  offsetOut,
    output logic [N_CH*4-1:0]   shiftDownOut,
    output logic [N_CH*6-1:0]   sampleAdjustOut
);
    localparam logic [CW-1:0] XM = CW'(X_MAX);
    localparam logic [CW-1:0] YM = CW'(Y_MAX);
    localparam logic [CW-1:0] OM = '1;
    logic [9:0]      r_sw1, r_sw2;
    logic [3:0]      w_evt, w_rpt, w_ok, w_pick;
    mode_e           w_mode;
    logic [CW-1:0]   r_x1, r_x2, r_y1, r_y2;
    logic            r_xen, r_yen;
    logic [N_CH-1:0] r_wen, r_hold;
    logic [CW-1:0]   r_off [N_CH];
    logic [3:0]      r_sd  [N_CH];
    logic [5:0]      r_sa  [N_CH];
    genvar g;
    for (g = 0; g < 4; g++) begin : g_btn
        button_conditioner #(
            .DEB_CYCLES(DEB_CYCLES),
            .RPT_DELAY (RPT_DELAY),
            .RPT_RATE  (RPT_RATE)
        ) u_btn (
            .clk     (buttonClock),
            .rst_n   (resetN),
            .i_butt_n(butt[g]),
            .o_evt   (w_evt[g]),
            .o_rpt   (w_rpt[g])
        );
    end
    // Repeats may only move cursors or step the offset; hold, shiftDown and sampleAdjust stay single-shot.
    always_comb begin
        w_mode = mode_e'(r_sw2[9:8]);
        w_ok   = w_evt | (w_rpt & (w_mode == MODE_CURSOR ? 4'hF : (w_mode == MODE_WAVE && r_sw2[1]) ? 4'hC : 4'h0));
        w_pick = w_ok[3] ? 4'b1000 : w_ok[2] ? 4'b0100 : w_ok[1] ? 4'b0010 : w_ok[0] ? 4'b0001 : 4'b0000;
    end
    always_ff @(posedge buttonClock) begin
        if (!resetN) begin
            r_sw1  <= '0;
            r_sw2  <= '0;
            r_x1   <= CW'(CUR_X1_RST);
            r_x2   <= CW'(CUR_X2_RST);
            r_y1   <= CW'(CUR_Y1_RST);
            r_y2   <= CW'(CUR_Y2_RST);
            r_xen  <= 1'b0;
            r_yen  <= 1'b0;
            r_wen  <= '0;
            r_hold <= '0;
            for (int k = 0; k < N_CH; k++) begin
                r_off[k] <= CW'(OFFSET_BASE + OFFSET_STEP * k);
                r_sd[k]  <= '0;
                r_sa[k]  <= '0;
            end
        end else begin
            r_sw1 <= switch;
            r_sw2 <= r_sw1;
            if (w_mode == MODE_CURSOR) begin
                r_xen <= r_sw2[0];
                r_yen <= r_sw2[1];
                case (r_sw2[3:2])
                    2'b01: begin
                        if (w_pick[3] && r_x1 < XM) r_x1 <= r_x1 + 1'b1;
                        if (w_pick[2] && r_x1 != '0) r_x1 <= r_x1 - 1'b1;
                        if (w_pick[1] && r_x2 < XM) r_x2 <= r_x2 + 1'b1;
                        if (w_pick[0] && r_x2 != '0) r_x2 <= r_x2 - 1'b1;
                    end
                    2'b10: begin
                        if (w_pick[3] && r_y1 < YM) r_y1 <= r_y1 + 1'b1;
                        if (w_pick[2] && r_y1 != '0) r_y1 <= r_y1 - 1'b1;
                        if (w_pick[1] && r_y2 < YM) r_y2 <= r_y2 + 1'b1;
                        if (w_pick[0] && r_y2 != '0) r_y2 <= r_y2 - 1'b1;
                    end
                    2'b11: begin
                        if (w_pick[3] && r_y1 < YM && r_y2 < YM) begin
                            r_y1 <= r_y1 + 1'b1;
                            r_y2 <= r_y2 + 1'b1;
                        end
                        if (w_pick[2] && r_y1 != '0 && r_y2 != '0) begin
                            r_y1 <= r_y1 - 1'b1;
                            r_y2 <= r_y2 - 1'b1;
                        end
                        if (w_pick[1] && r_x1 < XM && r_x2 < XM) begin
                            r_x1 <= r_x1 + 1'b1;
                            r_x2 <= r_x2 + 1'b1;
                        end
                        if (w_pick[0] && r_x1 != '0 && r_x2 != '0) begin
                            r_x1 <= r_x1 - 1'b1;
                            r_x2 <= r_x2 - 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            if (w_mode == MODE_WAVE) begin
                for (int k = 0; k < N_CH; k++) begin
                    if (r_sw2[7:4] == 4'(k)) begin
                        r_wen[k] <= r_sw2[0];
                        if (w_pick[1]) r_hold[k] <= 1'b1;
                        if (w_pick[0]) r_hold[k] <= 1'b0;
                        if (r_sw2[1]) begin
                            if (w_pick[3] && r_off[k] != OM) r_off[k] <= r_off[k] + 1'b1;
                            if (w_pick[2] && r_off[k] != '0) r_off[k] <= r_off[k] - 1'b1;
                        end else if (r_sw2[2]) begin
                            if (w_pick[3] && r_sd[k] != 4'(SHIFT_MAX)) r_sd[k] <= r_sd[k] + 1'b1;
                            if (w_pick[2] && r_sd[k] != '0) r_sd[k] <= r_sd[k] - 1'b1;
                        end else if (r_sw2[3]) begin
                            if (w_pick[3] && r_sa[k] != 6'(SA_MAX)) r_sa[k] <= r_sa[k] + 1'b1;
                            if (w_pick[2] && r_sa[k] != '0) r_sa[k] <= r_sa[k] - 1'b1;
                        end
                    end
                end
            end
        end
    end
    assign cursorX1Out   = r_x1;
    assign cursorX2Out   = r_x2;
    assign cursorY1Out   = r_y1;
    assign cursorY2Out   = r_y2;
    assign cursorX_ENOut = r_xen;
    assign cursorY_ENOut = r_yen;
    assign waveENOut     = r_wen;
    assign holdOut       = r_hold;
    for (g = 0; g < N_CH; g++) begin : g_pack
        assign offsetOut[g*CW +: CW]    = r_off[g];
        assign shiftDownOut[g*4 +: 4]   = r_sd[g];
        assign sampleAdjustOut[g*6 +: 6] = r_sa[g];
    end
endmodule

// File: tb/tb_scope_controls_multi.sv
// tb_scope_controls_multi: randomized and directed checks of scope_controls_multi against a behavioural model.
// Covers SCOPE_CTRL_AUTOREPEAT_EN behaviour when the macro is defined, single-shot holds otherwise.
module tb_scope_controls_multi;
    localparam int N_CH = 4;
    localparam int CW   = 11;
    localparam int DEB  = 4;
    localparam int RD   = 20;
    localparam int RR   = 5;
    localparam int WW   = N_CH * (2 + CW + 4 + 6);
    logic              clk = 1'b0;
    logic              resetN = 1'b0;
    logic [9:0]        sw = '0;
    logic [3:0]        butt = 4'hF;
    logic [CW-1:0]     x1, x2, y1, y2;
    logic              xen, yen;
    logic [N_CH-1:0]   wen, hold;
    logic [N_CH*CW-1:0] off;
    logic [N_CH*4-1:0] sd;
    logic [N_CH*6-1:0] sa;
    logic [4*CW+1:0]   a_cur;
    logic [WW-1:0]     a_wav;
    int checks = 0;
    int errors = 0;
    int m_x1, m_x2, m_y1, m_y2;
    logic m_xen, m_yen;
    logic [N_CH-1:0] m_wen, m_hold;
    int m_off [N_CH];
    int m_sd [N_CH];
    int m_sa [N_CH];
    logic [9:0] m_sw;
    scope_controls_multi #(
        .N_CH(N_CH), .CW(CW), .X_MAX(639), .Y_MAX(479),
        .DEB_CYCLES(DEB), .RPT_DELAY(RD), .RPT_RATE(RR)
    ) dut (
        .buttonClock(clk), .resetN(resetN), .switch(sw), .butt(butt),
        .cursorX1Out(x1), .cursorX2Out(x2), .cursorY1Out(y1), .cursorY2Out(y2),
        .cursorX_ENOut(xen), .cursorY_ENOut(yen), .waveENOut(wen), .holdOut(hold),
        .offsetOut(off), .shiftDownOut(sd), .sampleAdjustOut(sa)
    );
    always #5 clk = ~clk;
    assign a_cur = {x1, x2, y1, y2, xen, yen};
    assign a_wav = {wen, hold, off, sd, sa};
    function automatic int clamp(input int v, input int lo, input int hi);
        return v < lo ? lo : (v > hi ? hi : v);
    endfunction
    task automatic model_reset();
        m_x1 = 32; m_x2 = 90; m_y1 = 25; m_y2 = 100;
        m_xen = 0; m_yen = 0; m_wen = '0; m_hold = '0;
        for (int k = 0; k < N_CH; k++) begin
            m_off[k] = (30 + 170 * k) % (1 << CW);
            m_sd[k] = 0;
            m_sa[k] = 0;
        end
    endtask
    task automatic model_enables();
        int sel = int'(m_sw[7:4]);
        if (m_sw[9:8] == 2'b00) begin
            m_xen = m_sw[0];
            m_yen = m_sw[1];
        end
        if (m_sw[9:8] == 2'b01 && sel < N_CH) m_wen[sel] = m_sw[0];
    endtask
    task automatic model_press(input int b);
        int sel = int'(m_sw[7:4]);
        int d = (b % 2) ? 1 : -1;
        if (m_sw[9:8] == 2'b00) begin
            if (m_sw[3:2] == 2'b01) begin
                if (b >= 2) m_x1 = clamp(m_x1 + d, 0, 639); else m_x2 = clamp(m_x2 + d, 0, 639);
            end else if (m_sw[3:2] == 2'b10) begin
                if (b >= 2) m_y1 = clamp(m_y1 + d, 0, 479); else m_y2 = clamp(m_y2 + d, 0, 479);
            end else if (m_sw[3:2] == 2'b11) begin
                if (b >= 2 && m_y1 + d >= 0 && m_y1 + d <= 479 && m_y2 + d >= 0 && m_y2 + d <= 479) begin
                    m_y1 += d; m_y2 += d;
                end
                if (b < 2 && m_x1 + d >= 0 && m_x1 + d <= 639 && m_x2 + d >= 0 && m_x2 + d <= 639) begin
                    m_x1 += d; m_x2 += d;
                end
            end
        end else if (m_sw[9:8] == 2'b01 && sel < N_CH) begin
            if (b < 2) m_hold[sel] = (b == 1);
            else if (m_sw[1]) m_off[sel] = clamp(m_off[sel] + d, 0, (1 << CW) - 1);
            else if (m_sw[2]) m_sd[sel] = clamp(m_sd[sel] + d, 0, 15);
            else if (m_sw[3]) m_sa[sel] = clamp(m_sa[sel] + d, 0, 63);
        end
    endtask
    function automatic logic [4*CW+1:0] exp_cur();
        return {CW'(m_x1), CW'(m_x2), CW'(m_y1), CW'(m_y2), m_xen, m_yen};
    endfunction
    function automatic logic [WW-1:0] exp_wav();
        logic [N_CH*CW-1:0] o;
        logic [N_CH*4-1:0] s;
        logic [N_CH*6-1:0] a;
        for (int k = 0; k < N_CH; k++) begin
            o[k*CW +: CW] = CW'(m_off[k]);
            s[k*4 +: 4] = 4'(m_sd[k]);
            a[k*6 +: 6] = 6'(m_sa[k]);
        end
        return {m_wen, m_hold, o, s, a};
    endfunction
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic set_sw(input logic [9:0] v);
        sw = v;
        m_sw = v;
        tick(4);
        model_enables();
    endtask
    task automatic press(input logic [3:0] m, input int h);
        butt = ~m;
        tick(h);
        butt = 4'hF;
        tick(12);
    endtask
    task automatic do_reset();
        resetN = 1'b0;
        tick(3);
        resetN = 1'b1;
        model_reset();
        tick(10);
        model_enables();
    endtask
    task automatic test_reset();
        sw = '0; m_sw = '0; butt = 4'hF;
        resetN = 1'b0;
        tick(3);
        resetN = 1'b1;
        model_reset();
        checks++; if (a_cur !== exp_cur()) begin errors++; $display("FAIL reset_cur got=%h exp=%h", a_cur, exp_cur()); end
        checks++; if (a_wav !== exp_wav()) begin errors++; $display("FAIL reset_wav got=%h exp=%h", a_wav, exp_wav()); end
        checks++; if (off[2*CW +: CW] !== 11'd370) begin errors++; $display("FAIL reset_off2 got=%0d exp=370", off[2*CW +: CW]); end
        tick(10);
        model_enables();
    endtask
    task automatic test_enable_latency();
        sw = 10'b00_0000_0011; m_sw = sw;
        tick(2);
        checks++; if ({xen, yen} !== 2'b00) begin errors++; $display("FAIL en_early got=%b exp=00", {xen, yen}); end
        tick(1);
        model_enables();
        checks++; if ({xen, yen} !== 2'b11) begin errors++; $display("FAIL en_3cyc got=%b exp=11", {xen, yen}); end
    endtask
    task automatic test_latency();
        set_sw(10'b00_0000_0100);
        butt = 4'b0111;
        tick(DEB + 3);
        checks++; if (x1 !== CW'(m_x1)) begin errors++; $display("FAIL lat_early got=%0d exp=%0d", x1, m_x1); end
        tick(1);
        model_press(3);
        checks++; if (x1 !== CW'(m_x1)) begin errors++; $display("FAIL lat_edge got=%0d exp=%0d", x1, m_x1); end
        butt = 4'hF;
        tick(12);
    endtask
    task automatic test_bounce();
        do_reset();
        set_sw(10'b00_0000_0100);
        repeat (3) begin
            butt = 4'b0111; tick(2);
            butt = 4'hF; tick(2);
        end
        tick(8);
        checks++; if (x1 !== 11'd32) begin errors++; $display("FAIL bounce_none got=%0d exp=32", x1); end
        press(4'b1000, 10);
        model_press(3);
        checks++; if (x1 !== 11'd33) begin errors++; $display("FAIL bounce_once got=%0d exp=33", x1); end
        checks++; if (a_cur !== exp_cur()) begin errors++; $display("FAIL bounce_cur got=%h exp=%h", a_cur, exp_cur()); end
    endtask
    task automatic test_saturation();
        set_sw(10'b00_0000_1000);
        repeat (27) begin press(4'b0100, 6); model_press(2); end
        checks++; if (y1 !== '0) begin errors++; $display("FAIL y1_floor got=%0d exp=0", y1); end
        set_sw(10'b00_0000_1100);
        press(4'b0100, 6); model_press(2);
        checks++; if ({y1, y2} !== {11'd0, 11'd100}) begin errors++; $display("FAIL pair_dn got=%0d,%0d exp=0,100", y1, y2); end
        set_sw(10'b00_0000_1000);
        repeat (381) begin press(4'b0010, 6); model_press(1); end
        checks++; if (y2 !== 11'd479) begin errors++; $display("FAIL y2_ceil got=%0d exp=479", y2); end
        set_sw(10'b00_0000_1100);
        press(4'b1000, 6); model_press(3);
        checks++; if (a_cur !== exp_cur()) begin errors++; $display("FAIL pair_up got=%h exp=%h", a_cur, exp_cur()); end
    endtask
    task automatic test_channel();
        set_sw(10'b01_0010_0010);
        press(4'b1000, 6); model_press(3);
        checks++; if (off[2*CW +: CW] !== 11'd371) begin errors++; $display("FAIL ch2_off got=%0d exp=371", off[2*CW +: CW]); end
        checks++; if (a_wav !== exp_wav()) begin errors++; $display("FAIL ch2_wav got=%h exp=%h", a_wav, exp_wav()); end
        set_sw(10'b01_0101_0011);
        press(4'b1000, 6); model_press(3);
        press(4'b0010, 6); model_press(1);
        checks++; if (a_wav !== exp_wav()) begin errors++; $display("FAIL ch5_wav got=%h exp=%h", a_wav, exp_wav()); end
    endtask
    task automatic test_priority();
        set_sw(10'b01_0000_0100);
        press(4'b1001, 6); model_press(3);
        checks++; if ({sd[3:0], hold[0]} !== {4'd1, 1'b0}) begin errors++; $display("FAIL prio got=sd%0d,h%b exp=sd1,h0", sd[3:0], hold[0]); end
        checks++; if (a_wav !== exp_wav()) begin errors++; $display("FAIL prio_wav got=%h exp=%h", a_wav, exp_wav()); end
    endtask
    task automatic test_reset_held();
        set_sw(10'b00_0000_0100);
        butt = 4'b0111;
        tick(2);
        resetN = 1'b0;
        tick(3);
        resetN = 1'b1;
        model_reset();
        tick(15);
        model_enables();
        checks++; if (a_cur !== exp_cur()) begin errors++; $display("FAIL held_rst got=%h exp=%h", a_cur, exp_cur()); end
        butt = 4'hF;
        tick(12);
        checks++; if (x1 !== 11'd32) begin errors++; $display("FAIL held_release got=%0d exp=32", x1); end
        press(4'b1000, 6); model_press(3);
        checks++; if (x1 !== 11'd33) begin errors++; $display("FAIL held_repress got=%0d exp=33", x1); end
    endtask
    task automatic test_long_hold();
        do_reset();
        set_sw(10'b00_0000_0100);
        press(4'b1000, 40);
`ifdef SCOPE_CTRL_AUTOREPEAT_EN
        repeat (5) model_press(3);
        checks++; if (x1 !== 11'd37) begin errors++; $display("FAIL rpt_x1 got=%0d exp=37", x1); end
        set_sw(10'b01_0000_1000);
        press(4'b1000, 40); model_press(3);
        checks++; if (sa[5:0] !== 6'd1) begin errors++; $display("FAIL rpt_sa got=%0d exp=1", sa[5:0]); end
`else
        model_press(3);
        checks++; if (x1 !== 11'd33) begin errors++; $display("FAIL hold_x1 got=%0d exp=33", x1); end
        set_sw(10'b01_0000_0010);
        press(4'b1000, 40); model_press(3);
        checks++; if (off[CW-1:0] !== 11'd31) begin errors++; $display("FAIL hold_off got=%0d exp=31", off[CW-1:0]); end
`endif
        checks++; if (a_wav !== exp_wav()) begin errors++; $display("FAIL long_wav got=%h exp=%h", a_wav, exp_wav()); end
    endtask
    task automatic test_random();
        logic [9:0] v;
        logic [3:0] m;
        for (int i = 0; i < 60; i++) begin
            v = 10'($urandom);
            v[9:8] = ($urandom_range(0, 9) < 4) ? 2'b00 : ($urandom_range(0, 5) < 4) ? 2'b01 : 2'($urandom);
            v[7:4] = 4'($urandom_range(0, 5));
            m = 4'($urandom_range(1, 15));
            set_sw(v);
            press(m, 6);
            model_press(m[3] ? 3 : m[2] ? 2 : m[1] ? 1 : 0);
            checks++; if (a_cur !== exp_cur()) begin errors++; $display("FAIL rand_cur i=%0d sw=%b b=%b got=%h exp=%h", i, v, m, a_cur, exp_cur()); end
            checks++; if (a_wav !== exp_wav()) begin errors++; $display("FAIL rand_wav i=%0d sw=%b b=%b got=%h exp=%h", i, v, m, a_wav, exp_wav()); end
        end
    endtask
    initial begin
        test_reset();
        test_enable_latency();
        test_latency();
        test_bounce();
        test_saturation();
        test_channel();
        test_priority();
        test_reset_held();
        test_long_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
